// File: rtl/updown_counter_pkg.sv
// rtl/updown_counter_pkg.sv - shared types and helpers for the up/down modulo counter
package updown_counter_pkg;

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
  typedef enum logic [1:0] {NONE, UP, DOWN} dir_t;

  // Timer must hold the larger of the two reload values
  function automatic int timer_width(input int delay, input int period);
    int m;
    m = (delay > period) ? delay : period;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/updown_mod_counter_if.sv
// rtl/updown_mod_counter_if.sv - control and status bundle of the up/down modulo counter
interface updown_mod_counter_if #(
  parameter int WIDTH = 3
);
  logic             enable;
  logic             up;
  logic             down;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] out;
  logic             at_max;
  logic             at_min;
  logic             step;
  logic             wrapped;

  modport master (
    output enable, up, down, load, load_val,
    input  out, at_max, at_min, step, wrapped
  );

  modport slave (
    input  enable, up, down, load, load_val,
    output out, at_max, at_min, step, wrapped
  );
endinterface

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - multi-flop synchroniser for an asynchronous level input
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the raw level through the chain; oldest sample is the output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - modulo up/down counter with button auto-repeat
module updown_mod_counter
  import updown_counter_pkg::*;
#(
  parameter int WIDTH         = 3,
  parameter int MAX_VAL       = 5,
  parameter int WRAP          = 1,
  parameter int SYNC_STAGES   = 2,
  parameter int REPEAT_DELAY  = 12_500_000,
  parameter int REPEAT_PERIOD = 2_500_000
) (
  input logic                 clk,
  input logic                 reset,
  updown_mod_counter_if.slave bus
);

  localparam int               TW        = timer_width(REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [WIDTH-1:0] MAXV      = WIDTH'(MAX_VAL);
  localparam logic [TW-1:0]    DELAY_LD  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0]    PERIOD_LD = TW'(REPEAT_PERIOD - 1);

  if (WIDTH < 1 || MAX_VAL < 1 || MAX_VAL > (2 ** WIDTH) - 1) begin : g_bad_max
    $fatal(1, "updown_mod_counter: MAX_VAL does not fit WIDTH");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $fatal(1, "updown_mod_counter: SYNC_STAGES must be at least 2");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $fatal(1, "updown_mod_counter: repeat timing must be at least 1");
  end

  logic             up_s, down_s;
  dir_t             req;
  state_t           state_q, state_d;
  dir_t             dir_q, dir_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;
  logic             wrapped_q, wrapped_d;
  logic             fire;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync_up (
    .clk(clk), .reset(reset), .d_i(bus.up), .q_o(up_s)
  );

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync_down (
    .clk(clk), .reset(reset), .d_i(bus.down), .q_o(down_s)
  );

  // Decode the synchronised buttons; both pressed counts as no request
  always_comb begin
    req = NONE;
    if (up_s && !down_s)      req = UP;
    else if (down_s && !up_s) req = DOWN;
  end

  // Auto-repeat FSM, timer and step arithmetic
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    timer_d   = timer_q;
    cnt_d     = cnt_q;
    step_d    = 1'b0;
    wrapped_d = 1'b0;
    fire      = 1'b0;

    if (bus.load) begin
      cnt_d   = (bus.load_val > MAXV) ? MAXV : bus.load_val;
      state_d = IDLE;
      dir_d   = NONE;
      timer_d = '0;
    end else if (!bus.enable) begin
      state_d = IDLE;
      dir_d   = NONE;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req != NONE) begin
            fire    = 1'b1;
            dir_d   = req;
            timer_d = DELAY_LD;
            state_d = DELAY;
          end
        end
        DELAY, REPEAT: begin
          // Any change of request, including a direction swap, restarts from IDLE
          if (req != dir_q) begin
            state_d = IDLE;
            dir_d   = NONE;
            timer_d = '0;
          end else if (timer_q == '0) begin
            fire    = 1'b1;
            timer_d = PERIOD_LD;
            state_d = REPEAT;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        default: state_d = IDLE;
      endcase

      // A saturated step leaves the count alone and raises no pulse
      if (fire) begin
        if (req == UP) begin
          if (cnt_q != MAXV) begin
            cnt_d  = cnt_q + WIDTH'(1);
            step_d = 1'b1;
          end else if (WRAP != 0) begin
            cnt_d     = '0;
            step_d    = 1'b1;
            wrapped_d = 1'b1;
          end
        end else begin
          if (cnt_q != '0) begin
            cnt_d  = cnt_q - WIDTH'(1);
            step_d = 1'b1;
          end else if (WRAP != 0) begin
            cnt_d     = MAXV;
            step_d    = 1'b1;
            wrapped_d = 1'b1;
          end
        end
      end
    end
  end

  // State, timer, count and registered pulse outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      dir_q     <= NONE;
      timer_q   <= '0;
      cnt_q     <= '0;
      step_q    <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      timer_q   <= timer_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign bus.out     = cnt_q;
  assign bus.at_max  = (cnt_q == MAXV);
  assign bus.at_min  = (cnt_q == '0);
  assign bus.step    = step_q;
  assign bus.wrapped = wrapped_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb/tb_updown_mod_counter.sv - self-checking bench for the up/down modulo counter
module tb_updown_mod_counter;

  localparam int MAXV = 5;
  localparam int D    = 8;
  localparam int P    = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic       up = 1'b0;
  logic       down = 1'b0;
  logic       load = 1'b0;
  logic [2:0] load_val = 3'd0;
  bit         chk_en = 1'b0;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  updown_mod_counter_if #(.WIDTH(3)) bus_w ();
  updown_mod_counter_if #(.WIDTH(3)) bus_s ();

  assign bus_w.enable = enable;   assign bus_s.enable = enable;
  assign bus_w.up = up;           assign bus_s.up = up;
  assign bus_w.down = down;       assign bus_s.down = down;
  assign bus_w.load = load;       assign bus_s.load = load;
  assign bus_w.load_val = load_val; assign bus_s.load_val = load_val;

  updown_mod_counter #(.WIDTH(3), .MAX_VAL(MAXV), .WRAP(1), .SYNC_STAGES(2),
                       .REPEAT_DELAY(D), .REPEAT_PERIOD(P))
    dut_w (.clk(clk), .reset(reset), .bus(bus_w));

  updown_mod_counter #(.WIDTH(3), .MAX_VAL(MAXV), .WRAP(0), .SYNC_STAGES(2),
                       .REPEAT_DELAY(D), .REPEAT_PERIOD(P))
    dut_s (.clk(clk), .reset(reset), .bus(bus_s));

  // Model: count for the wrapping (w) and saturating (s) copies, shared hold
  // tracking (active, direction, edges since the first step), and the two
  // most recent raw button samples standing in for the synchroniser delay.
  typedef struct packed {
    int o_w; int o_s;
    bit st_w; bit st_s; bit wr_w; bit wr_s;
    bit act; int dir; int age;
    bit [1:0] h0; bit [1:0] h1;
  } ms_t;

  ms_t ms = '0;

  function automatic void step_one(input int o, input int d, input bit wrap,
                                   output int no, output bit st, output bit wr);
    no = o; st = 1'b0; wr = 1'b0;
    if (d == 1) begin
      if (o < MAXV) begin no = o + 1; st = 1'b1; end
      else if (wrap) begin no = 0; st = 1'b1; wr = 1'b1; end
    end else begin
      if (o > 0) begin no = o - 1; st = 1'b1; end
      else if (wrap) begin no = MAXV; st = 1'b1; wr = 1'b1; end
    end
  endfunction

  function automatic ms_t model_next(input ms_t c, input bit u, input bit dn,
                                     input bit ld, input bit en, input int lv);
    ms_t n;
    int  rq;
    bit  fire;
    n = c;
    fire = 1'b0;
    rq = (c.h0 == 2'b10) ? 1 : (c.h0 == 2'b01) ? 2 : 0;
    n.h0 = c.h1;
    n.h1 = {u, dn};
    n.st_w = 1'b0; n.st_s = 1'b0; n.wr_w = 1'b0; n.wr_s = 1'b0;
    if (ld) begin
      n.o_w = (lv > MAXV) ? MAXV : lv;
      n.o_s = n.o_w;
      n.act = 1'b0;
    end else if (!en) begin
      n.act = 1'b0;
    end else if (!c.act) begin
      if (rq != 0) begin n.act = 1'b1; n.dir = rq; n.age = 0; fire = 1'b1; end
    end else if (rq != c.dir) begin
      n.act = 1'b0;
    end else begin
      n.age = c.age + 1;
      if (n.age == D || (n.age > D && (n.age - D) % P == 0)) fire = 1'b1;
    end
    if (fire) begin
      step_one(c.o_w, n.dir, 1'b1, n.o_w, n.st_w, n.wr_w);
      step_one(c.o_s, n.dir, 1'b0, n.o_s, n.st_s, n.wr_s);
    end
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) ms <= '0;
    else        ms <= model_next(ms, up, down, load, enable, int'(load_val));
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic cmp_inst(input string tag, input int o, input bit st, input bit wr,
                          input logic [2:0] a_o, input logic a_max, input logic a_min,
                          input logic a_st, input logic a_wr);
    chk({"cmp_out_", tag}, 32'(a_o), o);
    chk({"cmp_at_max_", tag}, 32'(a_max), 32'(o == MAXV));
    chk({"cmp_at_min_", tag}, 32'(a_min), 32'(o == 0));
    chk({"cmp_step_", tag}, 32'(a_st), 32'(st));
    chk({"cmp_wrapped_", tag}, 32'(a_wr), 32'(wr));
  endtask

  // Every cycle, away from the active edge, both copies against the model
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst("w", ms.o_w, ms.st_w, ms.wr_w, bus_w.out, bus_w.at_max, bus_w.at_min,
               bus_w.step, bus_w.wrapped);
      cmp_inst("s", ms.o_s, ms.st_s, ms.wr_s, bus_s.out, bus_s.at_max, bus_s.at_min,
               bus_s.step, bus_s.wrapped);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [2:0] v);
    load = 1'b1;
    load_val = v;
    tick(1);
    load = 1'b0;
  endtask

  initial begin
    tick(3);
    chk_en = 1'b1;
    reset = 1'b1;
    tick(2);
    chk("t1_out", bus_w.out, 0);
    chk("t1_at_min", bus_w.at_min, 1);
    chk("t1_at_max", bus_w.at_max, 0);
    chk("t1_step", bus_w.step, 0);

    // 1-cycle up pulse from MAX: wrap to 0 at edge 3
    do_load(3'd5);
    chk("t2_load_out", bus_w.out, 5);
    chk("t2_load_at_max", bus_w.at_max, 1);
    up = 1'b1;
    tick(1);
    up = 1'b0;
    tick(1);
    chk("t2_e2_out", bus_w.out, 5);
    tick(1);
    chk("t2_e3_out", bus_w.out, 0);
    chk("t2_e3_step", bus_w.step, 1);
    chk("t2_e3_wrapped", bus_w.wrapped, 1);
    chk("t2_e3_at_min", bus_w.at_min, 1);
    chk("t2_e3_sat_out", bus_s.out, 5);
    chk("t2_e3_sat_step", bus_s.step, 0);
    tick(1);
    chk("t2_e4_step", bus_w.step, 0);
    chk("t2_e4_wrapped", bus_w.wrapped, 0);
    tick(4);

    // down held through edge 12: steps at 3, 11, 14
    do_load(3'd2);
    down = 1'b1;
    tick(3);
    chk("t3_e3_out", bus_w.out, 1);
    chk("t3_e3_step", bus_w.step, 1);
    tick(7);
    chk("t3_e10_out", bus_w.out, 1);
    tick(1);
    chk("t3_e11_out", bus_w.out, 0);
    chk("t3_e11_wrapped", bus_w.wrapped, 0);
    tick(1);
    down = 1'b0;
    tick(1);
    chk("t3_e13_out", bus_w.out, 0);
    tick(1);
    chk("t3_e14_out", bus_w.out, 5);
    chk("t3_e14_wrapped", bus_w.wrapped, 1);
    chk("t3_e14_sat_out", bus_s.out, 0);
    chk("t3_e14_sat_step", bus_s.step, 0);
    chk("t3_model_out", ms.o_w, 5);
    chk("t3_model_wr", ms.wr_w, 1);
    tick(6);
    chk("t3_e20_out", bus_w.out, 5);

    // saturating copy held at both ends
    do_load(3'd5);
    up = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      chk("t4_sat_out", bus_s.out, 5);
      chk("t4_sat_step", bus_s.step, 0);
      chk("t4_sat_wrapped", bus_s.wrapped, 0);
    end
    up = 1'b0;
    tick(4);
    do_load(3'd0);
    down = 1'b1;
    tick(1);
    down = 1'b0;
    tick(3);
    chk("t4_sat_min_out", bus_s.out, 0);
    chk("t4_wrap_min_out", bus_w.out, 5);
    chk("t4_model_pin", ms.o_s, 0);
    tick(3);

    // over-range load while up is held restarts the repeat sequence
    up = 1'b1;
    tick(6);
    load = 1'b1;
    load_val = 3'd7;
    tick(1);
    load = 1'b0;
    chk("t5_load_out", bus_w.out, 5);
    chk("t5_load_at_max", bus_w.at_max, 1);
    chk("t5_load_step", bus_w.step, 0);
    chk("t5_load_sat_out", bus_s.out, 5);
    tick(1);
    chk("t5_first_out", bus_w.out, 0);
    chk("t5_first_wrapped", bus_w.wrapped, 1);
    chk("t5_first_sat_step", bus_s.step, 0);
    tick(7);
    chk("t5_delay_out", bus_w.out, 0);
    tick(1);
    chk("t5_repeat_out", bus_w.out, 1);
    up = 1'b0;
    tick(5);

    // both buttons held: no change; releasing down steps three edges later
    do_load(3'd2);
    up = 1'b1;
    down = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      chk("t6_both_out", bus_w.out, 2);
    end
    down = 1'b0;
    tick(2);
    chk("t6_drop_e2_out", bus_w.out, 2);
    tick(1);
    chk("t6_drop_e3_out", bus_w.out, 3);
    chk("t6_drop_e3_sat_out", bus_s.out, 3);
    up = 1'b0;
    tick(5);

    // enable low with up held: no change; raising enable steps at next edge
    do_load(3'd1);
    enable = 1'b0;
    up = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      chk("t6_dis_out", bus_w.out, 1);
    end
    enable = 1'b1;
    tick(1);
    chk("t6_en_out", bus_w.out, 2);
    chk("t6_en_step", bus_w.step, 1);
    up = 1'b0;
    tick(5);

    // reset asserted while down is auto-repeating
    do_load(3'd4);
    down = 1'b1;
    tick(11);
    chk("t1b_pre_out", bus_w.out, 2);
    chk("t1b_pre_step", bus_w.step, 1);
    reset = 1'b0;
    #1;
    chk("t1b_out", bus_w.out, 0);
    chk("t1b_at_min", bus_w.at_min, 1);
    chk("t1b_at_max", bus_w.at_max, 0);
    chk("t1b_step", bus_w.step, 0);
    chk("t1b_wrapped", bus_w.wrapped, 0);
    chk("t1b_sat_out", bus_s.out, 0);
    down = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(4);
    chk("t1b_after_out", bus_w.out, 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
